// File: rtl/accel_core_neuron_engine_if.sv
// Bus between the accelerator core (master) and the fully-connected neuron engine (slave).
interface accel_core_neuron_engine_if #(
   parameter int unsigned NUM_W   = 3,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MAX_LEN = 16
);
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic                                 in_valid;
   logic [LEN_W-1:0]                     in_len;
   logic [LEN_W-1:0]                     out_len;
   logic [MAX_LEN*DATA_W-1:0]            in_data;
   logic                                 relu_en;
   logic [NUM_W-1:0]                     w_valid;
   logic [NUM_W*(MAX_LEN+1)*DATA_W-1:0]  w_data;
   logic [NUM_W*LEN_W-1:0]               w_len;
   logic [NUM_W*IDX_W-1:0]               w_neuron_idx;
   logic [NUM_W-1:0]                     w_release;
   logic [MAX_LEN*DATA_W-1:0]            out_data;
   logic [MAX_LEN-1:0]                   out_mask;
   logic                                 done_layer;
   logic                                 move_out_to_in;
   logic                                 err_len;

   modport master (
      output in_valid, in_len, out_len, in_data, relu_en,
      output w_valid, w_data, w_len, w_neuron_idx,
      input  w_release, out_data, out_mask, done_layer, move_out_to_in, err_len
   );

   modport slave (
      input  in_valid, in_len, out_len, in_data, relu_en,
      input  w_valid, w_data, w_len, w_neuron_idx,
      output w_release, out_data, out_mask, done_layer, move_out_to_in, err_len
   );
endinterface

// File: rtl/accel_core_neuron_engine.sv
// Fully-connected layer engine: round-robin over weight buffers, one serial
// signed MAC per neuron, bias add, optional ReLU, saturation into the output vector.
module accel_core_neuron_engine #(
   parameter int unsigned NUM_W   = 3,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned ACC_W   = 2 * DATA_W + $clog2(MAX_LEN + 1) + 1
) (
   input logic clk,
   input logic rst,
   accel_core_neuron_engine_if.slave bus
);
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned GNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
   localparam int unsigned BUF_W = (MAX_LEN + 1) * DATA_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (DATA_W - 1));

   typedef enum logic [2:0] {S_IDLE, S_ARB, S_MAC, S_BIAS, S_WRITE, S_DONE} state_t;

   state_t                     state_q, state_d;
   logic [GNT_W-1:0]           grant_q, last_grant_q, arb_idx_c;
   logic                       arb_hit_c, arb_err_c, err_mode_q;
   logic [IDX_W-1:0]           j_q, slot_c;
   logic signed [ACC_W-1:0]    acc_q, clamp_c;
   logic signed [DATA_W-1:0]   in_el_c, w_el_c, res_c;
   logic signed [2*DATA_W-1:0] prod_c;
   logic [NUM_W-1:0]           w_release_q;
   logic [MAX_LEN*DATA_W-1:0]  out_data_q;
   logic [MAX_LEN-1:0]         out_mask_q, mask_next_c, need_c;
   logic                       done_q, err_len_q, last_mac_c, layer_full_c;

   // Round-robin search from last_grant+1; a buffer released last cycle is held off.
   always_comb begin
      int cand;
      cand      = 0;
      arb_hit_c = 1'b0;
      arb_idx_c = '0;
      for (int off = 1; off <= int'(NUM_W); off++) begin
         cand = (int'(last_grant_q) + off) % int'(NUM_W);
         if (!arb_hit_c && bus.w_valid[GNT_W'(cand)] && !w_release_q[GNT_W'(cand)]) begin
            arb_hit_c = 1'b1;
            arb_idx_c = GNT_W'(cand);
         end
      end
      arb_err_c = (int'(bus.w_len[int'(arb_idx_c)*LEN_W +: LEN_W]) != int'(bus.in_len) + 1) ||
                  (int'(bus.w_neuron_idx[int'(arb_idx_c)*IDX_W +: IDX_W]) >= int'(bus.out_len));
   end

   // Operand selection: in BIAS the weight element at index N is the bias.
   always_comb begin
      int el;
      el      = (state_q == S_BIAS) ? int'(bus.in_len) : int'(j_q);
      in_el_c = bus.in_data[int'(j_q)*DATA_W +: DATA_W];
      w_el_c  = bus.w_data[int'(grant_q)*BUF_W + el*DATA_W +: DATA_W];
      prod_c  = in_el_c * w_el_c;
   end

   always_comb begin
      clamp_c = acc_q;
      if (bus.relu_en && acc_q < 0) clamp_c = '0;
      if (clamp_c > SAT_MAX)      clamp_c = SAT_MAX;
      else if (clamp_c < SAT_MIN) clamp_c = SAT_MIN;
      res_c = clamp_c[DATA_W-1:0];
   end

   // Layer completion looks at the mask as it will be after the current write.
   always_comb begin
      slot_c      = bus.w_neuron_idx[int'(grant_q)*IDX_W +: IDX_W];
      mask_next_c = out_mask_q;
      if (!err_mode_q) mask_next_c[slot_c] = 1'b1;
      for (int k = 0; k < int'(MAX_LEN); k++) need_c[k] = (k < int'(bus.out_len));
      layer_full_c = ((mask_next_c & need_c) == need_c);
      last_mac_c   = (int'(j_q) == int'(bus.in_len) - 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.in_valid) state_d = S_ARB;
         S_ARB:   if (!bus.in_valid) state_d = S_IDLE;
                  else if (arb_hit_c) state_d = arb_err_c ? S_WRITE : S_MAC;
         S_MAC:   if (!bus.in_valid) state_d = S_IDLE;
                  else if (last_mac_c) state_d = S_BIAS;
         S_BIAS:  state_d = bus.in_valid ? S_WRITE : S_IDLE;
         S_WRITE: if (!bus.in_valid) state_d = S_IDLE;
                  else state_d = layer_full_c ? S_DONE : S_ARB;
         S_DONE:  if (!bus.in_valid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q      <= '0;
         last_grant_q <= GNT_W'(NUM_W - 1);
         err_mode_q   <= 1'b0;
         j_q          <= '0;
         acc_q        <= '0;
         w_release_q  <= '0;
         out_data_q   <= '0;
         out_mask_q   <= '0;
         done_q       <= 1'b0;
         err_len_q    <= 1'b0;
      end else begin
         w_release_q <= '0;
         done_q      <= 1'b0;
         unique case (state_q)
            S_ARB: if (bus.in_valid && arb_hit_c) begin
               grant_q    <= arb_idx_c;
               err_mode_q <= arb_err_c;
               acc_q      <= '0;
               j_q        <= '0;
               if (arb_err_c) err_len_q <= 1'b1;
            end
            S_MAC: begin
               acc_q <= acc_q + ACC_W'(prod_c);
               j_q   <= j_q + 1'b1;
            end
            S_BIAS: acc_q <= acc_q + ACC_W'(w_el_c);
            S_WRITE: if (bus.in_valid) begin
               if (!err_mode_q) out_data_q[int'(slot_c)*DATA_W +: DATA_W] <= res_c;
               out_mask_q           <= mask_next_c;
               w_release_q[grant_q] <= 1'b1;
               last_grant_q         <= grant_q;
               done_q               <= layer_full_c;
            end
            default: ;
         endcase
         // Entering IDLE (layer end or abort) discards the layer's bookkeeping.
         if (state_d == S_IDLE) begin
            out_mask_q <= '0;
            err_len_q  <= 1'b0;
         end
      end
   end

   assign bus.w_release      = w_release_q;
   assign bus.out_data       = out_data_q;
   assign bus.out_mask       = out_mask_q;
   assign bus.done_layer     = done_q;
   assign bus.move_out_to_in = done_q;
   assign bus.err_len        = err_len_q;
endmodule

// File: tb/tb_accel_core_neuron_engine.sv
// Scoreboard bench for accel_core_neuron_engine: stimulus queues expected releases,
// done pulses and spot checks; a negedge monitor pops and compares them.
module tb_accel_core_neuron_engine;
   localparam int NUM_W   = 3;
   localparam int DATA_W  = 8;
   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
   localparam int IDX_W   = 4;
   localparam int BW      = MAX_LEN * DATA_W;

   typedef struct {
      int               bufi;
      int               slot;
      logic [7:0]       val;
      bit               err;
      bit               errlen;
      logic [15:0]      mask;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   exp_t           exp_q[$];
   int             done_exp_q[$];
   string          chk_name_q[$];
   logic [BW-1:0]  chk_act_q[$];
   logic [BW-1:0]  chk_exp_q[$];

   accel_core_neuron_engine_if #(.NUM_W(NUM_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) bus ();

   accel_core_neuron_engine #(.NUM_W(NUM_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void cmp(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   // Monitor: the only process that compares and steps the counters.
   initial begin
      exp_t e;
      logic [NUM_W-1:0] v;
      int k;
      forever begin
         @(negedge clk);
         while (chk_name_q.size() > 0)
            cmp(chk_name_q.pop_front(), chk_act_q.pop_front(), chk_exp_q.pop_front());
         if (bus.w_release != '0) begin
            if (exp_q.size() == 0) cmp("unexpected_release", BW'(bus.w_release), '0);
            else begin
               e = exp_q.pop_front();
               v = '0;
               v[e.bufi[1:0]] = 1'b1;
               cmp($sformatf("release_vec b%0d", e.bufi), BW'(bus.w_release), BW'(v));
               cmp($sformatf("release_cycle b%0d", e.bufi), BW'(cyc), BW'(e.cyc));
               cmp($sformatf("err_len b%0d", e.bufi), BW'(bus.err_len), BW'(e.errlen));
               cmp($sformatf("out_mask b%0d", e.bufi), BW'(bus.out_mask), BW'(e.mask));
               if (!e.err)
                  cmp($sformatf("out_slot%0d b%0d", e.slot, e.bufi),
                      BW'(bus.out_data[e.slot*DATA_W +: DATA_W]), BW'(e.val));
            end
         end
         if (bus.done_layer || bus.move_out_to_in) begin
            if (done_exp_q.size() == 0)
               cmp("unexpected_done", BW'({bus.done_layer, bus.move_out_to_in}), '0);
            else begin
               k = done_exp_q.pop_front();
               cmp("done_cycle", BW'(cyc), BW'(k));
               cmp("move_with_done", BW'(bus.move_out_to_in), BW'(bus.done_layer));
            end
         end
      end
   end

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
      chk_name_q.push_back(name);
      chk_act_q.push_back(act);
      chk_exp_q.push_back(expv);
   endtask

   task automatic set_valid(input int i, input bit v);
      bus.w_valid[i[1:0]] = v;
   endtask

   task automatic set_in(input int a0, input int a1);
      bus.in_data = '0;
      bus.in_data[0 +: DATA_W]      = DATA_W'(a0);
      bus.in_data[DATA_W +: DATA_W] = DATA_W'(a1);
   endtask

   task automatic load_buf(input int i, input int w0, input int w1, input int b, input int idx, input int len);
      int base;
      base = i * (MAX_LEN + 1) * DATA_W;
      bus.w_data[base +: DATA_W]              = DATA_W'(w0);
      bus.w_data[base + DATA_W +: DATA_W]     = DATA_W'(w1);
      bus.w_data[base + 2*DATA_W +: DATA_W]   = DATA_W'(b);
      bus.w_len[i*LEN_W +: LEN_W]             = LEN_W'(len);
      bus.w_neuron_idx[i*IDX_W +: IDX_W]      = IDX_W'(idx);
   endtask

   task automatic expect_rel(input int i, input int slot, input int val, input bit err,
                             input bit errlen, input logic [15:0] mask, input int c);
      exp_t e;
      e.bufi = i; e.slot = slot; e.val = 8'(val); e.err = err;
      e.errlen = errlen; e.mask = mask; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // End the current layer, confirm the clear on IDLE entry, start a new one; returns in ARB.
   task automatic start_layer(input int n, input int m, input bit relu);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("mask_cleared_idle", BW'(bus.out_mask), '0);
      chk("err_cleared_idle", BW'(bus.err_len), '0);
      bus.in_len  = LEN_W'(n);
      bus.out_len = LEN_W'(m);
      bus.relu_en = relu;
      bus.in_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_release(input int i);
      int n;
      n = 0;
      while (!bus.w_release[i[1:0]] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.w_release[i[1:0]]) chk($sformatf("release_timeout b%0d", i), '0, BW'(1));
   endtask

   // Raise one request at an ARB cycle, hold it through the release cycle, then drop it.
   task automatic serve(input int i, input int slot, input int val, input bit err,
                        input bit errlen, input logic [15:0] mask, input bit last);
      int k;
      set_valid(i, 1'b1);
      k = cyc + (err ? 2 : 5);
      expect_rel(i, slot, val, err, errlen, mask, k);
      if (last) done_exp_q.push_back(k);
      wait_release(i);
      @(negedge clk);
      set_valid(i, 1'b0);
   endtask

   task automatic load_basic();
      set_in(1, 2);
      load_buf(0, 3, 4, 5, 0, 3);
      load_buf(1, 6, 7, 8, 1, 3);
      load_buf(2, 9, 10, 11, 2, 3);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_len = '0; bus.out_len = '0; bus.in_data = '0;
      bus.relu_en = 1'b0; bus.w_valid = '0; bus.w_data = '0; bus.w_len = '0;
      bus.w_neuron_idx = '0;
      repeat (3) @(negedge clk);
      chk("reset_out_data", bus.out_data, '0);
      chk("reset_out_mask", BW'(bus.out_mask), '0);
      chk("reset_release", BW'(bus.w_release), '0);
      chk("reset_done", BW'({bus.done_layer, bus.move_out_to_in, bus.err_len}), '0);
      rst = 1'b0;
      @(negedge clk);

      // Basic: one request at a time
      load_basic();
      start_layer(2, 3, 1'b0);
      serve(0, 0, 16, 0, 0, 16'h1, 0);
      serve(1, 1, 28, 0, 0, 16'h3, 0);
      serve(2, 2, 40, 0, 0, 16'h7, 1);
      repeat (3) @(negedge clk);
      chk("mask_held_done", BW'(bus.out_mask), BW'(16'h7));

      // Simultaneous requests: grants 0,1,2 five cycles apart
      start_layer(2, 3, 1'b0);
      chk("out_data_retained", BW'(bus.out_data[23:0]), BW'(24'h281c10));
      bus.w_valid = 3'b111;
      k = cyc;
      expect_rel(0, 0, 16, 0, 0, 16'h1, k + 5);
      expect_rel(1, 1, 28, 0, 0, 16'h3, k + 10);
      expect_rel(2, 2, 40, 0, 0, 16'h7, k + 15);
      done_exp_q.push_back(k + 15);
      for (int i = 0; i < NUM_W; i++) begin
         wait_release(i);
         @(negedge clk);
         set_valid(i, 1'b0);
      end

      // Saturation both ways
      set_in(127, 127);
      load_buf(0, 127, 127, 0, 0, 3);
      start_layer(2, 1, 1'b0);
      serve(0, 0, 127, 0, 0, 16'h1, 1);
      load_buf(0, -128, -128, 0, 0, 3);
      start_layer(2, 1, 1'b0);
      serve(0, 0, -128, 0, 0, 16'h1, 1);

      // ReLU on and off
      set_in(1, 2);
      load_buf(0, -3, -4, 0, 0, 3);
      start_layer(2, 1, 1'b1);
      serve(0, 0, 0, 0, 0, 16'h1, 1);
      start_layer(2, 1, 1'b0);
      serve(0, 0, -11, 0, 0, 16'h1, 1);

      // Errors: bad length, then out-of-range slot; then a good neuron with err_len sticky
      set_in(1, 2);
      load_buf(0, 3, 4, 5, 0, 5);
      load_buf(1, 6, 7, 8, 3, 3);
      load_buf(2, 9, 10, 11, 1, 3);
      start_layer(2, 3, 1'b0);
      serve(0, 0, 0, 1, 1, 16'h0, 0);
      serve(1, 0, 0, 1, 1, 16'h0, 0);
      serve(2, 1, 40, 0, 1, 16'h2, 0);
      repeat (4) @(negedge clk);
      chk("err_len_sticky", BW'(bus.err_len), BW'(1));

      // Abort by dropping in_valid mid-MAC
      load_basic();
      start_layer(2, 3, 1'b0);
      serve(1, 1, 28, 0, 0, 16'h2, 0);
      set_valid(0, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      set_valid(0, 1'b0);
      repeat (6) @(negedge clk);
      chk("abort_mask_cleared", BW'(bus.out_mask), '0);
      start_layer(2, 3, 1'b0);
      serve(0, 0, 16, 0, 0, 16'h1, 0);
      serve(1, 1, 28, 0, 0, 16'h3, 0);
      serve(2, 2, 40, 0, 0, 16'h7, 1);

      // Abort by reset mid-MAC
      start_layer(2, 3, 1'b0);
      set_valid(0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.w_valid = '0;
      @(negedge clk);
      chk("rst_out_mask", BW'(bus.out_mask), '0);
      chk("rst_out_data", bus.out_data, '0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      start_layer(2, 3, 1'b0);
      serve(0, 0, 16, 0, 0, 16'h1, 0);
      serve(1, 1, 28, 0, 0, 16'h3, 0);
      serve(2, 2, 40, 0, 0, 16'h7, 1);

      repeat (6) @(negedge clk);
      chk("pending_releases", BW'(exp_q.size()), '0);
      chk("pending_done", BW'(done_exp_q.size()), '0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/accel_core_neuron_engine.md
# accel_core_neuron_engine

Parametrised fully-connected layer engine for the accelerator core. It consumes one input activation vector and a set of `NUM_W` independently loaded weight buffers, one neuron per buffer. For each neuron it computes a signed dot product plus bias, applies optional ReLU and saturation, and writes the result into the output vector. It is the generalised successor of the fixed three-buffer multiplier top: buffer count, element width, vector depth and post-processing mode are configurable, and it adds round-robin arbitration, error reporting and abort handling.

## Interface
- NUM_W, 3, number of weight buffers/requesters
- DATA_W, 8, signed element width (input, weight, bias, output)
- MAX_LEN, 16, max input/output vector length; weight buffer depth is MAX_LEN+1 (bias slot)
- ACC_W, 2*DATA_W+$clog2(MAX_LEN+1)+1, signed accumulator width
- LEN_W = $clog2(MAX_LEN+2), IDX_W = $clog2(MAX_LEN) (derived, localparam)

- Clock  in  1  single clock, all logic rising-edge
- Rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector owned by accelerator; low = layer abort/end
- in_len  in  LEN_W  input element count N (1..MAX_LEN)
- out_len  in  LEN_W  neuron count M for the layer (1..MAX_LEN)
- in_data  in  MAX_LEN*DATA_W  element j at [j*DATA_W +: DATA_W]
- relu_en  in  1  1 = clamp negative results to 0 before saturation
- w_valid  in  NUM_W  buffer i loaded and requesting service
- w_data  in  NUM_W*(MAX_LEN+1)*DATA_W  buffer i, element j; element N is the bias
- w_len  in  NUM_W*LEN_W  buffer i data length; must equal N+1
- w_neuron_idx  in  NUM_W*IDX_W  output slot for buffer i
- w_release  out  NUM_W  one-cycle pulse: buffer i consumed, may be reloaded
- out_data  out  MAX_LEN*DATA_W  output vector, slot k at [k*DATA_W +: DATA_W]
- out_mask  out  MAX_LEN  slot k written this layer
- done_layer  out  1  one-cycle pulse when slots 0..M-1 are all written
- move_out_to_in  out  1  one-cycle pulse, coincident with done_layer
- err_len  out  1  sticky: a buffer had w_len≠N+1 or neuron_idx≥M

## Operation
- FSM states: IDLE, ARB, MAC, BIAS, WRITE, DONE.
- IDLE → ARB when in_valid=1.
- ARB: round-robin grant among w_valid bits, searching from last_grant+1. Buffer i is masked for the single ARB cycle immediately after its own release.
  - No request: stay in ARB.
  - Grant with error (w_len≠in_len+1, or neuron_idx≥out_len): go to WRITE in error mode. Set err_len, skip the write, still release the buffer.
  - Valid grant: clear acc, j=0, go to MAC.
- MAC: one product per cycle, acc += sext(in_data[j])*sext(w_data[g][j]), j++. Leave for BIAS when j=N-1 is processed.
- BIAS: acc += sext(bias), where bias = w_data[g][N].
- WRITE: r = relu_en && acc<0 ? 0 : acc; saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Then:
  - out_data[idx] ← r, out_mask[idx] ← 1
  - w_release[g] pulses, last_grant ← g
  - A duplicate idx overwrites the slot.
  - Next state: DONE if out_mask[M-1:0] is all ones after this write, else ARB.
- DONE: done_layer and move_out_to_in pulse once, on entry. Hold until in_valid=0, then IDLE.
- IDLE entry clears out_mask and err_len. out_data is retained.
- in_valid=0 in ARB/MAC/BIAS/WRITE: abort to IDLE next cycle. No release pulse for an in-flight buffer, no write, mask cleared.
- w_data, in_data and lengths must be stable from grant until release. The engine does not register them.

## Timing
- Reset: state=IDLE, last_grant=NUM_W-1 (so buffer 0 wins first), out_data=0, out_mask=0, w_release=0, done_layer=0, move_out_to_in=0, err_len=0.
- Per neuron, ARB grant at cycle t:
  - MAC at t+1..t+N
  - BIAS at t+N+1
  - WRITE at t+N+2 (release pulse and out_data/out_mask visible after that edge)
  - next ARB at t+N+3
- Error neuron: ARB t → WRITE t+1, 2 cycles.
- done_layer asserts the cycle after the final WRITE.
- Requester must drop w_valid[i] within 1 cycle after its w_release[i]. The holdoff covers exactly that cycle.
- Simultaneous requests: exactly one grant per ARB; fairness means each waiting buffer is served within NUM_W grants.

## Test plan
- Basic, N=2, M=3, in=[1,2]; buffers 0/1/2 = [3,4,b5], [6,7,b8], [9,10,b11], idx 0/1/2, asserted one at a time → out=[16,28,40], each release 5 cycles after grant, one done_layer+move_out_to_in pulse.
- All three w_valid raised in the same cycle → grants 0,1,2 in order, release pulses 5 cycles apart, same outputs as above.
- Saturation, DATA_W=8: in=[127,127], w=[127,127,b0] → 127. in=[127,127], w=[-128,-128,b0] with relu_en=0 → -128 (0x80).
- ReLU: in=[1,2], w=[-3,-4,b0] → relu_en=1 gives 0, relu_en=0 gives -11 (0xF5).
- Error: w_len=5 with N=2 → err_len=1, release 2 cycles after grant, out_mask unchanged, no done_layer.
- Abort: drop in_valid in mid-MAC, and separately assert Rst mid-MAC → IDLE, no release pulse, out_mask=0. A new layer with the same inputs then completes correctly.
